// File: rtl/alu4.sv
// alu4: 4-bit registered ALU for the execute stage.
// Logic, shift, multiply, add/sub with flags, and compares; one-cycle latency.
module alu4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] aluop,
    output logic [3:0] y0,
    output logic [3:0] y1,
    output logic [1:0] ov
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0010;
    localparam logic [3:0] OP_NAND  = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_XNOR  = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_ADD   = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b1100;
    localparam logic [3:0] OP_SLT   = 4'b1101;
    localparam logic [3:0] OP_SLTU  = 4'b1110;

    logic [3:0] y0_d, y0_q;
    logic [3:0] y1_d, y1_q;
    logic [1:0] ov_d, ov_q;

    logic       sh_big;
    logic [1:0] sh_amt;
    logic [7:0] prod_u;
    logic [7:0] prod_s;
    logic [4:0] sum_add;
    logic [4:0] sum_sub;

    // Shared arithmetic terms; shift amounts of 4 or more saturate the shift.
    always_comb begin
        sh_big  = |B[3:2];
        sh_amt  = B[1:0];
        prod_u  = {4'b0000, A} * {4'b0000, B};
        prod_s  = 8'($signed({{4{A[3]}}, A}) * $signed({{4{B[3]}}, B}));
        sum_add = {1'b0, A} + {1'b0, B};
        sum_sub = {1'b0, A} + {1'b0, ~B} + 5'd1;
    end

    // Opcode decode; everything not set by an op stays zero.
    always_comb begin
        y0_d = 4'b0000;
        y1_d = 4'b0000;
        ov_d = 2'b00;
        case (aluop)
            OP_AND:   y0_d = A & B;
            OP_OR:    y0_d = A | B;
            OP_XOR:   y0_d = A ^ B;
            OP_NAND:  y0_d = ~(A & B);
            OP_NOR:   y0_d = ~(A | B);
            OP_XNOR:  y0_d = ~(A ^ B);
            OP_SLL:   y0_d = sh_big ? 4'b0000 : (A << sh_amt);
            OP_SRL:   y0_d = sh_big ? 4'b0000 : (A >> sh_amt);
            OP_SRA:   y0_d = sh_big ? {4{A[3]}}
                                    : 4'($signed(A) >>> sh_amt);
            OP_MULTU: {y1_d, y0_d} = prod_u;
            OP_MULT:  {y1_d, y0_d} = prod_s;
            OP_ADD: begin
                y0_d    = sum_add[3:0];
                ov_d[0] = sum_add[4];
                ov_d[1] = (A[3] == B[3]) && (sum_add[3] != A[3]);
            end
            OP_SUB: begin
                y0_d    = sum_sub[3:0];
                ov_d[0] = sum_sub[4];
                ov_d[1] = (A[3] != B[3]) && (sum_sub[3] != A[3]);
            end
            OP_SLT:   y0_d = {3'b000, $signed(A) < $signed(B)};
            OP_SLTU:  y0_d = {3'b000, A < B};
            default: begin
                y0_d = 4'b0000;
                y1_d = 4'b0000;
                ov_d = 2'b00;
            end
        endcase
    end

    // Result registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0_q <= 4'b0000;
            y1_q <= 4'b0000;
            ov_q <= 2'b00;
        end else begin
            y0_q <= y0_d;
            y1_q <= y1_d;
            ov_q <= ov_d;
        end
    end

    assign y0 = y0_q;
    assign y1 = y1_q;
    assign ov = ov_q;

endmodule

// File: tb/tb_alu4.sv
// tb_alu4: directed-vector bench for the 4-bit registered ALU.
// Each scenario task drives operands and checks the registered result.
module tb_alu4;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] aluop;
    logic [3:0] y0;
    logic [3:0] y1;
    logic [1:0] ov;

    int n_checks;
    int n_fails;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] y1;
        logic [3:0] y0;
        logic [1:0] ov;
    } vec_t;

    alu4 dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .aluop (aluop),
        .y0    (y0),
        .y1    (y1),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op);
        @(negedge clk);
        A = a;
        B = b;
        aluop = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({y1, y0, ov} !== 10'b0) begin
            n_fails++;
            $display("FAIL reset: got y1=%b y0=%b ov=%b, expected all 0",
                     y1, y0, ov);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_logic;
        vec_t v[6];
        v = '{
            '{4'b0101, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'b00},
            '{4'b0101, 4'b1000, 4'b0001, 4'b0000, 4'b1101, 2'b00},
            '{4'b0101, 4'b1000, 4'b0010, 4'b0000, 4'b1101, 2'b00},
            '{4'b0101, 4'b1000, 4'b0011, 4'b0000, 4'b1111, 2'b00},
            '{4'b0101, 4'b1000, 4'b0100, 4'b0000, 4'b0010, 2'b00},
            '{4'b0101, 4'b1000, 4'b0101, 4'b0000, 4'b0010, 2'b00}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_checks++;
            if ({y1, y0, ov} !== {v[i].y1, v[i].y0, v[i].ov}) begin
                n_fails++;
                $display("FAIL logic[%0d] op=%b: got y1=%b y0=%b ov=%b, expected y1=%b y0=%b ov=%b",
                         i, v[i].op, y1, y0, ov, v[i].y1, v[i].y0, v[i].ov);
            end
        end
    endtask

    task automatic test_shift;
        vec_t v[8];
        v = '{
            '{4'b0101, 4'b0011, 4'b0110, 4'b0000, 4'b1000, 2'b00},
            '{4'b1101, 4'b0010, 4'b0111, 4'b0000, 4'b0011, 2'b00},
            '{4'b1101, 4'b0001, 4'b1000, 4'b0000, 4'b1110, 2'b00},
            '{4'b1101, 4'b0101, 4'b0110, 4'b0000, 4'b0000, 2'b00},
            '{4'b1101, 4'b0101, 4'b0111, 4'b0000, 4'b0000, 2'b00},
            '{4'b1101, 4'b0101, 4'b1000, 4'b0000, 4'b1111, 2'b00},
            '{4'b0110, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 2'b00},
            '{4'b0001, 4'b1000, 4'b0110, 4'b0000, 4'b0000, 2'b00}
        };
        for (int i = 0; i < 8; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_checks++;
            if ({y1, y0, ov} !== {v[i].y1, v[i].y0, v[i].ov}) begin
                n_fails++;
                $display("FAIL shift[%0d] op=%b: got y1=%b y0=%b ov=%b, expected y1=%b y0=%b ov=%b",
                         i, v[i].op, y1, y0, ov, v[i].y1, v[i].y0, v[i].ov);
            end
        end
    endtask

    task automatic test_mult;
        vec_t v[4];
        v = '{
            '{4'b0101, 4'b1000, 4'b1001, 4'b0010, 4'b1000, 2'b00},
            '{4'b0101, 4'b1001, 4'b1010, 4'b1101, 4'b1101, 2'b00},
            '{4'b1000, 4'b1000, 4'b1010, 4'b0100, 4'b0000, 2'b00},
            '{4'b1111, 4'b1111, 4'b1001, 4'b1110, 4'b0001, 2'b00}
        };
        for (int i = 0; i < 4; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_checks++;
            if ({y1, y0, ov} !== {v[i].y1, v[i].y0, v[i].ov}) begin
                n_fails++;
                $display("FAIL mult[%0d] op=%b: got y1=%b y0=%b ov=%b, expected y1=%b y0=%b ov=%b",
                         i, v[i].op, y1, y0, ov, v[i].y1, v[i].y0, v[i].ov);
            end
        end
    endtask

    task automatic test_addsub;
        vec_t v[5];
        v = '{
            '{4'b0101, 4'b1000, 4'b1011, 4'b0000, 4'b1101, 2'b00},
            '{4'b1101, 4'b1000, 4'b1011, 4'b0000, 4'b0101, 2'b11},
            '{4'b0111, 4'b0100, 4'b1011, 4'b0000, 4'b1011, 2'b10},
            '{4'b1101, 4'b1001, 4'b1100, 4'b0000, 4'b0100, 2'b01},
            '{4'b0111, 4'b1000, 4'b1100, 4'b0000, 4'b1111, 2'b10}
        };
        for (int i = 0; i < 5; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_checks++;
            if ({y1, y0, ov} !== {v[i].y1, v[i].y0, v[i].ov}) begin
                n_fails++;
                $display("FAIL addsub[%0d] op=%b: got y1=%b y0=%b ov=%b, expected y1=%b y0=%b ov=%b",
                         i, v[i].op, y1, y0, ov, v[i].y1, v[i].y0, v[i].ov);
            end
        end
    endtask

    task automatic test_compare;
        vec_t v[5];
        v = '{
            '{4'b1101, 4'b0000, 4'b1101, 4'b0000, 4'b0001, 2'b00},
            '{4'b1101, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 2'b00},
            '{4'b0111, 4'b1000, 4'b1101, 4'b0000, 4'b0000, 2'b00},
            '{4'b0111, 4'b1000, 4'b1110, 4'b0000, 4'b0001, 2'b00},
            '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 2'b00}
        };
        for (int i = 0; i < 5; i++) begin
            apply(v[i].a, v[i].b, v[i].op);
            n_checks++;
            if ({y1, y0, ov} !== {v[i].y1, v[i].y0, v[i].ov}) begin
                n_fails++;
                $display("FAIL compare[%0d] op=%b: got y1=%b y0=%b ov=%b, expected y1=%b y0=%b ov=%b",
                         i, v[i].op, y1, y0, ov, v[i].y1, v[i].y0, v[i].ov);
            end
        end
    endtask

    task automatic test_async_reset;
        apply(4'b1101, 4'b1000, 4'b1011);
        n_checks++;
        if ({y1, y0, ov} !== {4'b0000, 4'b0101, 2'b11}) begin
            n_fails++;
            $display("FAIL async_pre: got y1=%b y0=%b ov=%b, expected y1=0000 y0=0101 ov=11",
                     y1, y0, ov);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({y1, y0, ov} !== 10'b0) begin
            n_fails++;
            $display("FAIL async_clear: got y1=%b y0=%b ov=%b, expected all 0",
                     y1, y0, ov);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({y1, y0, ov} !== 10'b0) begin
            n_fails++;
            $display("FAIL async_hold: got y1=%b y0=%b ov=%b, expected all 0",
                     y1, y0, ov);
        end
        @(negedge clk);
        rst = 1'b0;
        A = 4'b0101;
        B = 4'b1000;
        aluop = 4'b0001;
        #1;
        n_checks++;
        if ({y1, y0, ov} !== 10'b0) begin
            n_fails++;
            $display("FAIL async_wait: got y1=%b y0=%b ov=%b, expected all 0 before edge",
                     y1, y0, ov);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({y1, y0, ov} !== {4'b0000, 4'b1101, 2'b00}) begin
            n_fails++;
            $display("FAIL async_resume: got y1=%b y0=%b ov=%b, expected y1=0000 y0=1101 ov=00",
                     y1, y0, ov);
        end
    endtask

    task automatic test_back_to_back;
        apply(4'b1111, 4'b1111, 4'b1001);
        n_checks++;
        if ({y1, y0, ov} !== {4'b1110, 4'b0001, 2'b00}) begin
            n_fails++;
            $display("FAIL b2b_mul: got y1=%b y0=%b ov=%b, expected y1=1110 y0=0001 ov=00",
                     y1, y0, ov);
        end
        apply(4'b1101, 4'b1000, 4'b1011);
        n_checks++;
        if ({y1, y0, ov} !== {4'b0000, 4'b0101, 2'b11}) begin
            n_fails++;
            $display("FAIL b2b_add: got y1=%b y0=%b ov=%b, expected y1=0000 y0=0101 ov=11",
                     y1, y0, ov);
        end
        apply(4'b0101, 4'b1000, 4'b0000);
        n_checks++;
        if ({y1, y0, ov} !== 10'b0) begin
            n_fails++;
            $display("FAIL b2b_and: got y1=%b y0=%b ov=%b, expected all 0",
                     y1, y0, ov);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst   = 1'b1;
        A     = 4'b0000;
        B     = 4'b0000;
        aluop = 4'b0000;
        test_reset();
        test_logic();
        test_shift();
        test_mult();
        test_addsub();
        test_compare();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
